// File: rtl/udp_timeout_sched.sv
// udp_timeout_sched: multi-channel timeout scheduler for the UDP path.
// Channels are armed with a tick count and count down on a shared timer
// tick. Expired channels are reported one at a time through a registered
// valid/ready slot, chosen round-robin.
// Optional feature macro: UDP_TIMEOUT_PERIODIC_EN adds periodic reload
// channels (arm_periodic input, sticky overrun output).
module udp_timeout_sched #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CH_W   = 2,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tick_in,
   input  logic              arm_valid,
   input  logic [CH_W-1:0]   arm_ch,
   input  logic [CNT_W-1:0]  arm_count,
   input  logic              cancel_valid,
   input  logic [CH_W-1:0]   cancel_ch,
   output logic              expire_valid,
   output logic [CH_W-1:0]   expire_ch,
   input  logic              expire_ready,
`ifdef UDP_TIMEOUT_PERIODIC_EN
   input  logic              arm_periodic,
   output logic [NUM_CH-1:0] overrun,
`endif
   output logic [NUM_CH-1:0] active
);

   logic [NUM_CH-1:0]            r_running;
   logic [NUM_CH-1:0]            r_pending;
   logic [NUM_CH-1:0][CNT_W-1:0] r_count;
   logic                         r_expire_valid;
   logic [CH_W-1:0]              r_expire_ch;
   logic [CH_W-1:0]              r_rr_ptr;

   logic [NUM_CH-1:0]            w_running_d;
   logic [NUM_CH-1:0]            w_pending_d;
   logic [NUM_CH-1:0][CNT_W-1:0] w_count_d;

   logic                         w_arm_in_range;
   logic                         w_cancel_in_range;
   logic                         w_slot_free;
   logic                         w_load;
   logic                         w_sel_found;
   logic [CH_W-1:0]              w_sel_ch;
   logic [CH_W-1:0]              w_rr_next;

`ifdef UDP_TIMEOUT_PERIODIC_EN
   logic [NUM_CH-1:0]            r_periodic;
   logic [NUM_CH-1:0]            r_overrun;
   logic [NUM_CH-1:0][CNT_W-1:0] r_reload;
   logic [NUM_CH-1:0]            w_periodic_d;
   logic [NUM_CH-1:0]            w_overrun_d;
   logic [NUM_CH-1:0][CNT_W-1:0] w_reload_d;
   logic [NUM_CH-1:0]            w_unconsumed;

   assign overrun = r_overrun;
`endif

   assign w_arm_in_range    = 32'(arm_ch) < NUM_CH;
   assign w_cancel_in_range = 32'(cancel_ch) < NUM_CH;
   assign w_slot_free       = !r_expire_valid || expire_ready;
   assign w_load            = w_slot_free && w_sel_found;

   assign expire_valid = r_expire_valid;
   assign expire_ch    = r_expire_ch;
   assign active       = r_running;

   // Round-robin pick: lowest pending channel at or above the pointer, else lowest overall
   always_comb begin
      logic            v_hi_found;
      logic [CH_W-1:0] v_hi_ch;
      logic [CH_W-1:0] v_lo_ch;
      v_hi_found  = 1'b0;
      v_hi_ch     = '0;
      v_lo_ch     = '0;
      w_sel_found = 1'b0;
      for (int c = NUM_CH - 1; c >= 0; c--) begin
         if (r_pending[c]) begin
            if (CH_W'(c) >= r_rr_ptr) begin
               v_hi_found = 1'b1;
               v_hi_ch    = CH_W'(c);
            end
            w_sel_found = 1'b1;
            v_lo_ch     = CH_W'(c);
         end
      end
      w_sel_ch  = v_hi_found ? v_hi_ch : v_lo_ch;
      w_rr_next = (w_sel_ch == CH_W'(NUM_CH - 1)) ? '0 : w_sel_ch + 1'b1;
   end

`ifdef UDP_TIMEOUT_PERIODIC_EN
   // A previous report is still outstanding if it is pending (and not being
   // taken this edge) or sitting in the slot without being accepted.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         w_unconsumed[c] = (r_pending[c] && !(w_load && (w_sel_ch == CH_W'(c)))) ||
                           (r_expire_valid && (r_expire_ch == CH_W'(c)) && !expire_ready);
      end
   end
`endif

   // Per-channel next state: cancel beats arm, arm beats tick, new expiry beats slot load
   always_comb begin
      w_running_d = r_running;
      w_pending_d = r_pending;
      w_count_d   = r_count;
`ifdef UDP_TIMEOUT_PERIODIC_EN
      w_periodic_d = r_periodic;
      w_overrun_d  = r_overrun;
      w_reload_d   = r_reload;
`endif
      for (int c = 0; c < NUM_CH; c++) begin
         if (w_load && (w_sel_ch == CH_W'(c))) begin
            w_pending_d[c] = 1'b0;
         end
         if (cancel_valid && w_cancel_in_range && (cancel_ch == CH_W'(c))) begin
            w_running_d[c] = 1'b0;
            w_pending_d[c] = 1'b0;
            w_count_d[c]   = '0;
`ifdef UDP_TIMEOUT_PERIODIC_EN
            w_periodic_d[c] = 1'b0;
            w_overrun_d[c]  = 1'b0;
`endif
         end else if (arm_valid && w_arm_in_range && (arm_ch == CH_W'(c))) begin
            if (arm_count == '0) begin
               w_running_d[c] = 1'b0;
               w_pending_d[c] = 1'b1;
               w_count_d[c]   = '0;
            end else begin
               w_running_d[c] = 1'b1;
               w_pending_d[c] = 1'b0;
               w_count_d[c]   = arm_count;
            end
`ifdef UDP_TIMEOUT_PERIODIC_EN
            // Zero-count periodic arm degenerates to one-shot
            w_periodic_d[c] = arm_periodic && (arm_count != '0);
            w_reload_d[c]   = arm_count;
            w_overrun_d[c]  = 1'b0;
`endif
         end else if (tick_in && r_running[c]) begin
            if (r_count[c] == CNT_W'(1)) begin
               w_pending_d[c] = 1'b1;
`ifdef UDP_TIMEOUT_PERIODIC_EN
               if (r_periodic[c]) begin
                  w_count_d[c] = r_reload[c];
                  if (w_unconsumed[c]) begin
                     w_overrun_d[c] = 1'b1;
                  end
               end else begin
                  w_running_d[c] = 1'b0;
                  w_count_d[c]   = '0;
               end
`else
               w_running_d[c] = 1'b0;
               w_count_d[c]   = '0;
`endif
            end else begin
               w_count_d[c] = r_count[c] - 1'b1;
            end
         end
      end
   end

   // Channel state registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_running <= '0;
         r_pending <= '0;
         r_count   <= '0;
      end else begin
         r_running <= w_running_d;
         r_pending <= w_pending_d;
         r_count   <= w_count_d;
      end
   end

`ifdef UDP_TIMEOUT_PERIODIC_EN
   // Periodic configuration and sticky overrun flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_periodic <= '0;
         r_overrun  <= '0;
         r_reload   <= '0;
      end else begin
         r_periodic <= w_periodic_d;
         r_overrun  <= w_overrun_d;
         r_reload   <= w_reload_d;
      end
   end
`endif

   // Report slot and round-robin pointer; slot holds until accepted
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_expire_valid <= 1'b0;
         r_expire_ch    <= '0;
         r_rr_ptr       <= '0;
      end else if (w_slot_free) begin
         r_expire_valid <= w_sel_found;
         if (w_sel_found) begin
            r_expire_ch <= w_sel_ch;
            r_rr_ptr    <= w_rr_next;
         end
      end
   end

endmodule

// File: tb/tb_udp_timeout_sched.sv
// Scoreboard bench for udp_timeout_sched: stimulus pushes expected report
// channels, a negedge monitor compares every presented report.
module tb_udp_timeout_sched;

   logic       clk = 1'b0;
   logic       reset;
   logic       tick_in;
   logic       arm_valid;
   logic [1:0] arm_ch;
   logic [7:0] arm_count;
   logic       cancel_valid;
   logic [1:0] cancel_ch;
   logic       expire_valid;
   logic [1:0] expire_ch;
   logic       expire_ready;
   logic [3:0] active;
`ifdef UDP_TIMEOUT_PERIODIC_EN
   logic       arm_periodic;
   logic [3:0] overrun;
`endif

   int n_chk  = 0;
   int n_pass = 0;
   int sb[$];

   always #5 clk = ~clk;

   udp_timeout_sched #(
      .NUM_CH (4),
      .CH_W   (2),
      .CNT_W  (8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .tick_in      (tick_in),
      .arm_valid    (arm_valid),
      .arm_ch       (arm_ch),
      .arm_count    (arm_count),
      .cancel_valid (cancel_valid),
      .cancel_ch    (cancel_ch),
      .expire_valid (expire_valid),
      .expire_ch    (expire_ch),
      .expire_ready (expire_ready),
`ifdef UDP_TIMEOUT_PERIODIC_EN
      .arm_periodic (arm_periodic),
      .overrun      (overrun),
`endif
      .active       (active)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Advance one edge, then drop single-cycle pulses
   task automatic step();
      @(posedge clk);
      #1;
      tick_in      = 1'b0;
      arm_valid    = 1'b0;
      cancel_valid = 1'b0;
   endtask

   task automatic arm(input int ch, input int cnt);
      arm_valid = 1'b1;
      arm_ch    = 2'(ch);
      arm_count = 8'(cnt);
      step();
   endtask

   task automatic tick();
      tick_in = 1'b1;
      step();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      sb.delete();
      step();
      reset = 1'b0;
   endtask

   // Monitor: every presented report must match the scoreboard head
   always @(negedge clk) begin
      if (!reset && expire_valid) begin
         chk("report_expected", int'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            chk("report_ch", expire_ch, sb[0]);
            if (expire_ready) void'(sb.pop_front());
         end
      end
   end

   initial begin
      reset        = 1'b1;
      tick_in      = 1'b0;
      arm_valid    = 1'b0;
      arm_ch       = '0;
      arm_count    = '0;
      cancel_valid = 1'b0;
      cancel_ch    = '0;
      expire_ready = 1'b1;
`ifdef UDP_TIMEOUT_PERIODIC_EN
      arm_periodic = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset_valid", expire_valid, 0);
      chk("reset_ch", expire_ch, 0);
      chk("reset_active", active, 0);

      // Single channel, count 3, tick every 4 cycles
      arm(1, 3);
      sb.push_back(1);
      for (int k = 1; k <= 3; k++) begin
         repeat (3) step();
         tick();
         @(negedge clk);
         if (k < 3) chk("t1_active_running", active[1], 1);
         else begin
            chk("t1_active_fall", active[1], 0);
            chk("t1_no_early_valid", expire_valid, 0);
         end
      end
      step();
      @(negedge clk);
      chk("t1_valid", expire_valid, 1);
      chk("t1_ch", expire_ch, 1);
      step();
      @(negedge clk);
      chk("t1_valid_drop", expire_valid, 0);

      // Three channels expire on one tick, reported 0,2,3 back-to-back
      do_reset();
      arm(0, 1); sb.push_back(0);
      arm(2, 1); sb.push_back(2);
      arm(3, 1); sb.push_back(3);
      tick();
      @(negedge clk);
      chk("t2_pending_latency", expire_valid, 0);
      for (int k = 0; k < 3; k++) begin
         step();
         @(negedge clk);
         chk("t2_valid", expire_valid, 1);
         chk("t2_order", expire_ch, (k == 0) ? 0 : k + 1);
      end
      step();
      @(negedge clk);
      chk("t2_drain", expire_valid, 0);

      // Same with back-pressure: report 0 held for 5 cycles
      do_reset();
      arm(0, 1); sb.push_back(0);
      arm(2, 1); sb.push_back(2);
      arm(3, 1); sb.push_back(3);
      expire_ready = 1'b0;
      tick();
      step();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("t3_hold_valid", expire_valid, 1);
         chk("t3_hold_ch", expire_ch, 0);
         step();
      end
      expire_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t3_order", expire_ch, (k == 0) ? 0 : k + 1);
         step();
      end
      @(negedge clk);
      chk("t3_drain", expire_valid, 0);

      // Cancel mid-count; arm+cancel in same cycle
      do_reset();
      arm(2, 5);
      tick(); step();
      tick(); step();
      cancel_valid = 1'b1;
      cancel_ch    = 2'd2;
      step();
      for (int k = 0; k < 10; k++) begin
         tick(); step();
      end
      @(negedge clk);
      chk("t4_active_cancel", active[2], 0);
      chk("t4_no_report", expire_valid, 0);
      arm_valid    = 1'b1;
      arm_ch       = 2'd2;
      arm_count    = 8'd4;
      cancel_valid = 1'b1;
      cancel_ch    = 2'd2;
      step();
      @(negedge clk);
      chk("t4_cancel_wins", active[2], 0);

      // Arm coincident with tick keeps the full count; zero count expires at once
      do_reset();
      tick_in = 1'b1;
      arm(1, 2);
      sb.push_back(1);
      @(negedge clk);
      chk("t5_armed", active[1], 1);
      tick();
      @(negedge clk);
      chk("t5_no_decrement", active[1], 1);
      tick();
      @(negedge clk);
      chk("t5_expired", active[1], 0);
      step();
      @(negedge clk);
      chk("t5_valid", expire_valid, 1);
      chk("t5_ch", expire_ch, 1);
      step();
      arm(3, 0);
      sb.push_back(3);
      @(negedge clk);
      chk("t5_zero_not_yet", expire_valid, 0);
      chk("t5_zero_inactive", active[3], 0);
      step();
      @(negedge clk);
      chk("t5_zero_valid", expire_valid, 1);
      chk("t5_zero_ch", expire_ch, 3);
      step();

      // Asynchronous reset drops an in-flight report
      expire_ready = 1'b0;
      arm(2, 9);
      arm(1, 0);
      sb.push_back(1);
      step();
      @(negedge clk);
      chk("t6_inflight", expire_valid, 1);
      #2 reset = 1'b1;
      sb.delete();
      #1;
      chk("t6_async_valid", expire_valid, 0);
      chk("t6_async_ch", expire_ch, 0);
      chk("t6_async_active", active, 0);
      step();
      reset        = 1'b0;
      expire_ready = 1'b1;
      repeat (3) step();
      @(negedge clk);
      chk("t6_quiet", expire_valid, 0);

`ifdef UDP_TIMEOUT_PERIODIC_EN
      // Periodic channel overruns while its report is unaccepted
      do_reset();
      expire_ready = 1'b0;
      arm_periodic = 1'b1;
      arm(3, 2);
      arm_periodic = 1'b0;
      sb.push_back(3);
      tick(); step();
      tick(); step();
      @(negedge clk);
      chk("p_first_report", expire_valid, 1);
      chk("p_no_overrun_yet", overrun[3], 0);
      tick(); step();
      tick(); step();
      @(negedge clk);
      chk("p_overrun", overrun[3], 1);
      chk("p_still_active", active[3], 1);
      cancel_valid = 1'b1;
      cancel_ch    = 2'd3;
      step();
      @(negedge clk);
      chk("p_overrun_clear", overrun[3], 0);
      expire_ready = 1'b1;
      step();
      step();
      @(negedge clk);
      chk("p_drain", expire_valid, 0);
`endif

      chk("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
